bfm_rr_sched: RTL
=================

Name: bfm_rr_sched

Overview:
- Round-robin scheduler that shares the single operand port of the bfm datapath (A_s/B_s in, res_o out, 8-bit) between N_REQ independent operand-pair producers.
- Accepts per-requester valid/ready beats and drives one operand pair per cycle into the bfm.
- Tracks in-flight IDs through the bfm latency and returns each result tagged with its requester ID.
- Toggles a per-requester batch flag every BATCH accepted beats, replacing the single-stream xmit_en handshake.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ITEM_WIDTH, 8, operand and result width
- BFM_LAT, 1, cycles from bfm operand register update to valid res_o (1..4)
- BATCH, 100, beats per requester before its batch flag toggles
- BURST, 4, max consecutive grants to one requester (used only with the optional feature)

Ports:
- clk_i  in  1  clock; all logic on posedge
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  N_REQ  per-requester operand pair valid
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero
- req_a_i  in  N_REQ*ITEM_WIDTH  packed A operands; requester k at [k*ITEM_WIDTH +: ITEM_WIDTH]
- req_b_i  in  N_REQ*ITEM_WIDTH  packed B operands, same packing
- bfm_a_o  out  ITEM_WIDTH  to bfm A_s
- bfm_b_o  out  ITEM_WIDTH  to bfm B_s
- bfm_res_i  in  ITEM_WIDTH  from bfm res_o
- rsp_valid_o  out  1  result valid, single-cycle pulse per result
- rsp_id_o  out  $clog2(N_REQ)  requester ID of the result
- rsp_data_o  out  ITEM_WIDTH  result value
- batch_tgl_o  out  N_REQ  per-requester batch-complete toggle

Behaviour:
- Reset (reset_i=1 at posedge), values from the next cycle:
  - bfm_a_o/bfm_b_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, batch_tgl_o=0, req_ready_o=0.
  - RR pointer=0, in-flight pipeline cleared, batch counters=0.
- Reset mid-operation: in-flight results are discarded, never presented.
- Arbitration (combinational within the cycle):
  - req_ready_o[k]=1 for exactly the first requester with req_valid_i set, searching from ptr upward with wrap-around.
  - No requester valid: req_ready_o=0.
  - Handshake on req_valid_i[k]&&req_ready_o[k].
- On a handshake with requester g:
  - bfm_a_o<=A[g], bfm_b_o<=B[g].
  - Push {1,g} into the BFM_LAT+1 deep valid/ID shift pipe.
  - ptr<=(g+1) mod N_REQ.
- No handshake: bfm operands hold their value, push {0,x}, ptr unchanged.
- Result output: when the pipe tail is valid, rsp_valid_o<=1, rsp_id_o<=tail ID, rsp_data_o<=bfm_res_i. Total latency from handshake edge to rsp_valid_o high is BFM_LAT+1 cycles.
- Sustained throughput is 1 beat/cycle. No response backpressure; consumers must always accept.
- Batch: per-requester counter incremented on its handshake. On reaching BATCH-1 and accepting, the counter wraps to 0 and batch_tgl_o[k] inverts in the same cycle.
- Requester dropping valid without handshake: no state change; ptr unchanged.
- Single requester continuously valid: granted every cycle.

Optional Feature:
- Macro: BFM_RR_SCHED_BURST_EN
- Defined:
  - FSM has states ARB and HOLD.
  - ARB: on a handshake with g, latch g, set burst count=1, go to HOLD.
  - HOLD: g keeps priority while valid and count<BURST; count increments per beat.
  - Exit to ARB with ptr=g+1 when count reaches BURST or when g deasserts valid. In the deassert case another valid requester is granted in that same cycle.
  - Reset forces ARB.
- Undefined: pure per-beat round-robin; no HOLD state or burst counter logic.

Decomposition:
- Package bfm_sched_pkg:
  - ID_W=$clog2(N_REQ) helper function
  - typedef sched_state_e {ARB, HOLD}
  - typedef inflight_t {valid, id}
- One sub-module, rr_arbiter: req vector + ptr -> one-hot grant and encoded index. Purely combinational, reused for both modes.

Test Plan:
- Reset held 3 cycles with all req_valid_i=1 -> req_ready_o=0, rsp_valid_o=0, batch_tgl_o=0. First grant goes to req 0 on the cycle after release.
- All 4 valid continuously, A=k, B=10*k, BFM = adder -> grants cycle 0,1,2,3,0…; rsp_id 0,1,2,3 with data 0,11,22,33. First rsp_valid_o is 2 cycles after the first handshake (BFM_LAT=1).
- Only req 2 valid for 5 cycles, then req 1 and 3 together -> req 2 gets 5 consecutive grants; then req 3 is granted (ptr=3), then req 1.
- BATCH=3, req 0 alone sends 7 beats -> batch_tgl_o[0] rises on beat 3, falls on beat 6; other bits stay 0.
- Assert reset_i with 2 beats in flight -> no rsp_valid_o pulse after reset; next accepted beat returns the correct ID.
- BFM_RR_SCHED_BURST_EN, BURST=4, req 0 and 1 always valid -> grant pattern 0,0,0,0,1,1,1,1,0…

Source files
------------

// File: rtl/bfm_sched_pkg.sv
// Shared types and helpers for the bfm round-robin scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bfm_sched_pkg;

    // Widest requester ID ever carried in the in-flight pipe (N_REQ up to 8).
    localparam int MAX_ID_W = 3;

    // Bit width needed to index n items; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Burst scheduling states: free arbitration, or holding a requester's burst.
    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } sched_state_e;

    // One slot of the in-flight tracker: a beat is in the bfm for requester id.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } inflight_t;

endpackage

// File: rtl/bfm_rr_sched_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; grant is zero when no request is set.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Scan from ptr upward; the first hit wins and later hits are ignored.
    always_comb begin
        int k;
        k     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr_i) + i) % N_REQ;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/bfm_rr_sched.sv
// Shares the bfm operand port between N_REQ producers; returns tagged results.
// Latency: handshake edge to rsp_valid_o high is BFM_LAT+1 cycles; 1 beat/cycle.
// Backpressure: one-hot req_ready_o per cycle; no response backpressure.
// Optional BFM_RR_SCHED_BURST_EN: a granted requester keeps priority for up to BURST beats.
module bfm_rr_sched
    import bfm_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ITEM_WIDTH = 8,
    parameter int BFM_LAT    = 1,
    parameter int BATCH      = 100,
    parameter int BURST      = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ*ITEM_WIDTH-1:0]   req_a_i,
    input  logic [N_REQ*ITEM_WIDTH-1:0]   req_b_i,
    output logic [ITEM_WIDTH-1:0]         bfm_a_o,
    output logic [ITEM_WIDTH-1:0]         bfm_b_o,
    input  logic [ITEM_WIDTH-1:0]         bfm_res_i,
    output logic                          rsp_valid_o,
    output logic [$clog2(N_REQ)-1:0]      rsp_id_o,
    output logic [ITEM_WIDTH-1:0]         rsp_data_o,
    output logic [N_REQ-1:0]              batch_tgl_o
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = id_w(BATCH);

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       arb_ptr;
    logic [N_REQ-1:0]      gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;
    logic                  hs;

    logic [ITEM_WIDTH-1:0] bfm_a_q, bfm_a_d;
    logic [ITEM_WIDTH-1:0] bfm_b_q, bfm_b_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [ITEM_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0]      batch_tgl_q, batch_tgl_d;
    logic [CNT_W-1:0]      batch_cnt_q [N_REQ];
    logic [CNT_W-1:0]      batch_cnt_d [N_REQ];
    inflight_t             pipe_q [BFM_LAT+1];
    inflight_t             pipe_d [BFM_LAT+1];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (arb_ptr),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Nothing is accepted while reset is asserted.
    assign req_ready_o = reset_i ? '0 : gnt;
    assign hs          = gnt_any & ~reset_i;

`ifdef BFM_RR_SCHED_BURST_EN
    localparam int BURST_W = id_w(BURST + 1);

    sched_state_e         state_q, state_d;
    logic [ID_W-1:0]      hold_id_q, hold_id_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                 keep;

    // The held requester outranks the rotation only while valid and under budget.
    assign keep    = (state_q == HOLD) && req_valid_i[hold_id_q]
                     && (burst_cnt_q < BURST_W'(BURST));
    assign arb_ptr = keep ? hold_id_q : ptr_q;

    // Burst FSM: a fresh grant opens a burst; a continued grant extends it.
    always_comb begin
        state_d     = state_q;
        hold_id_d   = hold_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB: begin
                if (hs) begin
                    state_d     = HOLD;
                    hold_id_d   = gnt_idx;
                    burst_cnt_d = BURST_W'(1);
                end
            end
            HOLD: begin
                if (hs && keep) begin
                    burst_cnt_d = burst_cnt_q + BURST_W'(1);
                end else if (hs) begin
                    // Budget spent or holder dropped: the new winner starts its own burst.
                    hold_id_d   = gnt_idx;
                    burst_cnt_d = BURST_W'(1);
                end else begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Burst state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ARB;
            hold_id_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_id_q   <= hold_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign arb_ptr = ptr_q;
`endif

    // Accept path, in-flight ID pipe, result capture and batch counting.
    always_comb begin
        ptr_d       = ptr_q;
        bfm_a_d     = bfm_a_q;
        bfm_b_d     = bfm_b_q;
        batch_tgl_d = batch_tgl_q;
        for (int k = 0; k < N_REQ; k++) begin
            batch_cnt_d[k] = batch_cnt_q[k];
        end

        if (hs) begin
            bfm_a_d = req_a_i[int'(gnt_idx)*ITEM_WIDTH +: ITEM_WIDTH];
            bfm_b_d = req_b_i[int'(gnt_idx)*ITEM_WIDTH +: ITEM_WIDTH];
            if (int'(gnt_idx) == N_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + ID_W'(1);
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt[k]) begin
                    if (batch_cnt_q[k] == CNT_W'(BATCH - 1)) begin
                        batch_cnt_d[k] = '0;
                        batch_tgl_d[k] = ~batch_tgl_q[k];
                    end else begin
                        batch_cnt_d[k] = batch_cnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end

        // Slot 0 records this cycle's beat; the tail lines up with bfm_res_i.
        pipe_d[0].valid = hs;
        pipe_d[0].id    = MAX_ID_W'(gnt_idx);
        for (int j = 1; j <= BFM_LAT; j++) begin
            pipe_d[j] = pipe_q[j-1];
        end

        rsp_valid_d = pipe_q[BFM_LAT].valid;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (pipe_q[BFM_LAT].valid) begin
            rsp_id_d   = ID_W'(pipe_q[BFM_LAT].id);
            rsp_data_d = bfm_res_i;
        end
    end

    // State registers; reset also drops any beats still in the bfm.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            bfm_a_q     <= '0;
            bfm_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            batch_tgl_q <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                batch_cnt_q[k] <= '0;
            end
            for (int j = 0; j <= BFM_LAT; j++) begin
                pipe_q[j] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            bfm_a_q     <= bfm_a_d;
            bfm_b_q     <= bfm_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            batch_tgl_q <= batch_tgl_d;
            for (int k = 0; k < N_REQ; k++) begin
                batch_cnt_q[k] <= batch_cnt_d[k];
            end
            for (int j = 0; j <= BFM_LAT; j++) begin
                pipe_q[j] <= pipe_d[j];
            end
        end
    end

    assign bfm_a_o     = bfm_a_q;
    assign bfm_b_o     = bfm_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign batch_tgl_o = batch_tgl_q;

endmodule
